// File: rtl/hw_cipher_pkg.sv
// hw_cipher_pkg
// Shared definitions for the hw_encrypt / hw_decrypt cipher pair:
//   - FSM state type and state codes
//   - round count, key pre-expansion step count and round constants
//   - 4-bit substitution table (inverse direction, as used by invsbox)
//   - swap16w, forward key schedule f and inverse key schedule finv
package hw_cipher_pkg;

    localparam int ROUNDS       = 12;
    localparam int KEYEXP_STEPS = 11;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_LOAD   = 3'd1;
    localparam state_t ST_KEYEXP = 3'd2;
    localparam state_t ST_ROUND  = 3'd3;
    localparam state_t ST_DONE   = 3'd4;

    // Nibble n of this constant is invsbox(n). The forward S-box is derived
    // from it so the two directions can never drift apart.
    localparam logic [63:0] INV_SBOX4 = 64'hA970_364B_D21C_8FE5;

    function automatic logic [6:0] round_const(input logic [3:0] i);
        logic [6:0] c;
        case (i)
            4'd0:    c = 7'h5A;
            4'd1:    c = 7'h34;
            4'd2:    c = 7'h73;
            4'd3:    c = 7'h66;
            4'd4:    c = 7'h57;
            4'd5:    c = 7'h35;
            4'd6:    c = 7'h71;
            4'd7:    c = 7'h62;
            4'd8:    c = 7'h5F;
            4'd9:    c = 7'h25;
            4'd10:   c = 7'h51;
            4'd11:   c = 7'h22;
            default: c = 7'h00;
        endcase
        return c;
    endfunction

    // Swaps the 16-bit halves inside each 32-bit word; it is its own inverse.
    function automatic logic [63:0] swap16w(input logic [63:0] x);
        return {x[47:32], x[63:48], x[15:0], x[31:16]};
    endfunction

    // Forward key schedule on rk = {H, L}.
    function automatic logic [127:0] f(input logic [127:0] rk);
        logic [63:0] h;
        logic [63:0] l;
        h = rk[127:64];
        l = rk[63:0];
        return {h ^ l, swap16w(h)};
    endfunction

    // Inverse key schedule: finv(f(k)) == k.
    function automatic logic [127:0] finv(input logic [127:0] rk);
        logic [63:0] s;
        s = swap16w(rk[63:0]);
        return {s, rk[127:64] ^ s};
    endfunction

endpackage

// File: rtl/sbox.sv
// sbox
// Combinational 32-bit forward S-box: each of the eight nibbles is
// substituted independently. The 4-bit table is the inverse of the one held
// in INV_SBOX4, so sbox and invsbox undo each other exactly.
// Ports:
//   din   in  32  word to substitute
//   dout  out 32  substituted word
module sbox
    import hw_cipher_pkg::*;
(
    input  logic [31:0] din,
    output logic [31:0] dout
);

    // Search the inverse table for the entry that maps back to x.
    function automatic logic [3:0] fwd_nib(input logic [3:0] x);
        logic [3:0] r;
        r = 4'h0;
        for (int v = 0; v < 16; v++) begin
            if (INV_SBOX4[v*4 +: 4] == x) begin
                r = 4'(v);
            end
        end
        return r;
    endfunction

    for (genvar n = 0; n < 8; n++) begin : g_nib
        assign dout[n*4 +: 4] = fwd_nib(din[n*4 +: 4]);
    end

endmodule

// File: rtl/hw_encrypt.sv
// hw_encrypt
// Memory-mapped 128-bit block-cipher encryption engine. The host writes four
// plaintext words and four key words (LSW first) to address 0, waits while
// waitrequest is high (11 key pre-expansion steps + 12 rounds), then reads
// four ciphertext words (LSW first) from address 0.
// Optional feature macro: HW_ENCRYPT_STATUS_EN
//   defined   : address 1 is a status register {29'b0, done, busy, loading},
//               readable in any state without stalling; writes to it ignored
//   undefined : address is ignored, every access goes to the data port
// Ports:
//   clk          in  1   clock, rising edge
//   reset        in  1   synchronous, active-high
//   address      in  1   0 = data port, 1 = status
//   write        in  1   write strobe
//   writedata    in  32  plaintext / key word
//   read         in  1   read strobe
//   readdata     out 32  registered read data
//   waitrequest  out 1   high while busy computing
module hw_encrypt
    import hw_cipher_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        address,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic        read,
    output logic [31:0] readdata,
    output logic        waitrequest
);

    localparam logic [3:0] KEYEXP_LAST = 4'(KEYEXP_STEPS - 1);
    localparam logic [3:0] ROUND_LAST  = 4'(ROUNDS - 1);

    state_t         state;
    logic [127:0]   text;
    logic [127:0]   key;
    logic [127:0]   rk;
    logic [2:0]     idx;
    logic [3:0]     cnt;

    logic           busy;
    logic           data_sel;
    logic           status_sel;
    logic           wr_data;
    logic           rd_data;

    logic [63:0]    l1;
    logic [63:0]    r1;
    logic [63:0]    y;
    logic [63:0]    x;
    logic [63:0]    s;
    logic [127:0]   text_round;

`ifdef HW_ENCRYPT_STATUS_EN
    logic [31:0]    status_word;

    assign data_sel    = ~address;
    assign status_sel  = address;
    assign status_word = {29'b0, state == ST_DONE, busy, state == ST_LOAD};
`else
    logic           unused_address;

    assign unused_address = address;
    assign data_sel       = 1'b1;
    assign status_sel     = 1'b0;
`endif

    assign busy = (state == ST_KEYEXP) || (state == ST_ROUND);

    // Status accesses must never stall, so they are exempt from waitrequest.
    assign waitrequest = busy & ~status_sel;

    // A simultaneous write takes precedence, so a read only counts on its own.
    assign wr_data = write & ~waitrequest & data_sel;
    assign rd_data = read & ~write & ~waitrequest & data_sel;

    // One encryption round on the current text and round key.
    assign l1 = text[127:64] ^ rk[127:64];
    assign r1 = text[63:0] ^ rk[63:0] ^ {43'b0, round_const(cnt), 14'b0};
    assign y  = swap16w(r1);
    assign x  = {y[42:0], y[63:43]};

    sbox u_sbox_hi (
        .din  (l1[63:32]),
        .dout (s[63:32])
    );

    sbox u_sbox_lo (
        .din  (l1[31:0]),
        .dout (s[31:0])
    );

    assign text_round = {x ^ s, s};

    // Main sequencer: word loading, key pre-expansion, rounds and read-out.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            text  <= '0;
            key   <= '0;
            rk    <= '0;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (wr_data) begin
                        text[31:0] <= writedata;
                        idx        <= 3'd1;
                        state      <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (wr_data) begin
                        if (!idx[2]) begin
                            text[{idx[1:0], 5'b00000} +: 32] <= writedata;
                        end else begin
                            key[{idx[1:0], 5'b00000} +: 32] <= writedata;
                        end
                        if (idx == 3'd7) begin
                            // The last key word is still in flight, so build rk from it directly.
                            rk    <= {writedata, key[95:0]};
                            cnt   <= '0;
                            idx   <= '0;
                            state <= ST_KEYEXP;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                ST_KEYEXP: begin
                    rk <= f(rk);
                    if (cnt == KEYEXP_LAST) begin
                        cnt   <= '0;
                        state <= ST_ROUND;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ST_ROUND: begin
                    text <= text_round;
                    rk   <= finv(rk);
                    if (cnt == ROUND_LAST) begin
                        cnt   <= '0;
                        idx   <= '0;
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ST_DONE: begin
                    if (wr_data) begin
                        text[31:0] <= writedata;
                        idx        <= 3'd1;
                        state      <= ST_LOAD;
                    end else if (rd_data) begin
                        if (idx == 3'd3) begin
                            idx   <= '0;
                            state <= ST_IDLE;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Read data register: only an accepted read updates it; anything that is
    // not a ciphertext or status read returns zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= '0;
        end else if (read && !waitrequest) begin
            if (write) begin
                readdata <= '0;
            end else if (rd_data && (state == ST_DONE)) begin
                readdata <= text[{idx[1:0], 5'b00000} +: 32];
`ifdef HW_ENCRYPT_STATUS_EN
            end else if (status_sel) begin
                readdata <= status_word;
`endif
            end else begin
                readdata <= '0;
            end
        end
    end

endmodule
